// File: rtl/pic_prio_ctrl.sv
// pic_prio_ctrl -- programmable interrupt controller core with 8259-style
// initialisation (ICW1..ICW3), operation commands (OCW1..OCW3), rotating
// priority, edge/level request capture and a two-pulse acknowledge sequence.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   wr, rd, a0, din    register write/read strobes, address bit, write data
//   dout               registered read data (IMR, IRR or ISR, zero-filled)
//   irq                request lines, already synchronous to clk
//   inta               acknowledge pulses; two pulses form one sequence
//   intr               registered interrupt request to the CPU
//   vec, vec_valid     vector (base | level), pulsed on the second inta
//   imr_o/isr_o/irr_o  mask, in-service and request registers
//   init_done          high once initialisation has completed
module pic_prio_ctrl #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned IDW   = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic             a0,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic [N_IRQ-1:0] irq,
  input  logic             inta,
  output logic             intr,
  output logic [7:0]       vec,
  output logic             vec_valid,
  output logic [N_IRQ-1:0] imr_o,
  output logic [N_IRQ-1:0] isr_o,
  output logic [N_IRQ-1:0] irr_o,
  output logic             init_done
);

  typedef enum logic [1:0] {S_IDLE, S_ICW2, S_ICW3, S_READY} state_t;
  state_t state, state_nx;

  logic [N_IRQ-1:0] imr, isr, irr, irq_q;
  logic [N_IRQ-1:0] isr_nx, irr_nx, isr_set, isr_clr, irr_ack, rd_mux;
  logic [IDW-1:0]   lp, lp_nx, cur_id, ack_id, lvl;
  logic [7:0]       base;
  logic             ltim, sngl, aeoi, rot_aeoi, rdsel, seq_open, seq_open_nx;

  // Command decode
  logic ready, icw1, icw2_wr, ocw1, ocw2, ocw3;
  logic inta_ok, first_ack, second_ack;

  assign ready      = (state == S_READY);
  assign icw1       = wr && !a0 && din[4];
  assign icw2_wr    = (state == S_ICW2) && wr && a0;
  assign ocw1       = ready && wr && a0;
  assign ocw2       = ready && wr && !a0 && (din[4:3] == 2'b00);
  assign ocw3       = ready && wr && !a0 && (din[4:3] == 2'b01);
  assign inta_ok    = inta && ready;
  assign first_ack  = inta_ok && !seq_open;
  assign second_ack = inta_ok && seq_open;
  assign lvl        = din[IDW-1:0];

  // Init FSM: ICW1 restarts from any state
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (icw1) begin
      state_nx = S_ICW2;
    end else begin
      case (state)
        S_ICW2:  if (wr && a0) state_nx = sngl ? S_READY : S_ICW3;
        S_ICW3:  if (wr && a0) state_nx = S_READY;
        default: ;
      endcase
    end
  end

  // Priority resolution. Rank 0 is level lp+1; ranks wrap naturally in IDW
  // bits because N_IRQ is a power of two.
  logic [IDW:0]   isr_min, elig_min;
  logic [IDW-1:0] isr_top, elig_id;
  logic           isr_any, elig_any;

  always_comb begin
    logic [IDW-1:0] r;
    r        = '0;
    isr_min  = (IDW+1)'(N_IRQ);
    isr_top  = '0;
    isr_any  = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      r = IDW'(i) - lp - IDW'(1);
      if (isr[i] && ({1'b0, r} < isr_min)) begin
        isr_min = {1'b0, r};
        isr_top = IDW'(i);
        isr_any = 1'b1;
      end
    end
    elig_min = (IDW+1)'(N_IRQ);
    elig_id  = '0;
    elig_any = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      r = IDW'(i) - lp - IDW'(1);
      if (irr[i] && !imr[i] && ({1'b0, r} < isr_min) && ({1'b0, r} < elig_min)) begin
        elig_min = {1'b0, r};
        elig_id  = IDW'(i);
        elig_any = 1'b1;
      end
    end
  end

  // Next-state for ISR, IRR, lp and the acknowledge sequence. The inta action
  // is computed from current values and the write is layered on top; an ISR
  // set from the first inta beats any clear in the same cycle.
  always_comb begin
    ack_id  = elig_any ? elig_id : IDW'(N_IRQ-1);
    isr_set = '0;
    irr_ack = '0;
    isr_clr = '0;
    lp_nx   = lp;
    if (first_ack && elig_any) begin
      isr_set = N_IRQ'(1) << ack_id;
      if (!ltim) irr_ack = N_IRQ'(1) << ack_id;
    end
    if (second_ack && aeoi) begin
      isr_clr[cur_id] = 1'b1;
      if (rot_aeoi) lp_nx = cur_id;
    end
    if (ocw2) begin
      case (din[7:5])
        3'b001: if (isr_any) isr_clr[isr_top] = 1'b1;
        3'b011: isr_clr[lvl] = 1'b1;
        3'b101: if (isr_any) begin
                  isr_clr[isr_top] = 1'b1;
                  lp_nx = isr_top;
                end
        3'b111: begin
                  isr_clr[lvl] = 1'b1;
                  lp_nx = lvl;
                end
        3'b110: lp_nx = lvl;
        default: ;
      endcase
    end
    if (icw1) begin
      isr_nx      = '0;
      irr_nx      = '0;
      lp_nx       = IDW'(N_IRQ-1);
      seq_open_nx = 1'b0;
    end else begin
      isr_nx      = (isr & ~isr_clr) | isr_set;
      irr_nx      = ltim ? irq : ((irr | (irq & ~irq_q)) & irq & ~irr_ack);
      seq_open_nx = first_ack ? 1'b1 : (second_ack ? 1'b0 : seq_open);
    end
    rd_mux = a0 ? imr : (rdsel ? isr : irr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q     <= '0;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      lp        <= IDW'(N_IRQ-1);
      cur_id    <= '0;
      base      <= '0;
      ltim      <= 1'b0;
      sngl      <= 1'b0;
      aeoi      <= 1'b0;
      rot_aeoi  <= 1'b0;
      rdsel     <= 1'b0;
      seq_open  <= 1'b0;
      intr      <= 1'b0;
      vec       <= '0;
      vec_valid <= 1'b0;
      dout      <= '0;
    end else begin
      irq_q     <= irq;
      irr       <= irr_nx;
      isr       <= isr_nx;
      lp        <= lp_nx;
      seq_open  <= seq_open_nx;
      intr      <= (state_nx == S_READY) && !seq_open_nx && elig_any;
      vec_valid <= second_ack && !icw1;
      if (second_ack && !icw1) vec <= base | 8'(cur_id);
      if (first_ack) cur_id <= ack_id;
      if (icw1) begin
        ltim     <= din[3];
        sngl     <= din[1];
        aeoi     <= din[0];
        imr      <= '0;
        rot_aeoi <= 1'b0;
      end
      if (icw2_wr) base <= din & ~8'(N_IRQ-1);
      if (ocw1) imr <= din[N_IRQ-1:0];
      if (ocw2 && din[7:5] == 3'b100) rot_aeoi <= 1'b1;
      if (ocw2 && din[7:5] == 3'b000) rot_aeoi <= 1'b0;
      if (ocw3 && din[1]) rdsel <= din[0];
      if (rd) dout <= 8'(rd_mux);
    end
  end

  assign imr_o     = imr;
  assign isr_o     = isr;
  assign irr_o     = irr;
  assign init_done = ready;

endmodule

// File: doc/pic_prio_ctrl.md
PIC_PRIO_CTRL -- requirements
Module: pic_prio_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8, number of request lines; legal values 2, 4, 8.
REQ-002 Parameter IDW, default $clog2(N_IRQ), width of the IR level index.
REQ-003 clk  in  1  single clock; every state change occurs on its rising edge.
REQ-004 reset  in  1  reset; synchronous, active-high.
REQ-005 wr  in  1  one-cycle write strobe; samples a0 and din.
REQ-006 rd  in  1  one-cycle read strobe; samples a0.
REQ-007 a0  in  1  register-select address bit.
REQ-008 din  in  8  write data: ICW1-3 and OCW1-3.
REQ-009 dout  out  8  registered read data.
REQ-010 irq  in  N_IRQ  asynchronous-free request lines, already synchronous to clk.
REQ-011 inta  in  1  one-cycle acknowledge pulse; two pulses form one acknowledge sequence.
REQ-012 intr  out  1  registered interrupt request to the CPU.
REQ-013 vec  out  8  interrupt vector, valid when vec_valid is high.
REQ-014 vec_valid  out  1  one-cycle pulse on the second inta.
REQ-015 imr_o, isr_o, irr_o  out  N_IRQ each  mask, in-service and request registers.
REQ-016 init_done  out  1  high in READY state.

Function
REQ-017 Init FSM states: IDLE, ICW2, ICW3, READY. The FSM SHALL move through them on writes as follows.
- Any state, wr with a0=0 and din[4]=1: this is ICW1; go to ICW2.
- ICW1 latches LTIM=din[3], SNGL=din[1], AEOI=din[0].
- ICW1 clears IMR, ISR, IRR, rotate-in-AEOI and the inta phase.
- ICW1 sets the lowest-priority pointer lp=N_IRQ-1.
REQ-018 In ICW2, wr with a0=1 SHALL latch base=din with the low IDW bits forced to 0, then go to ICW3 if SNGL=0, else to READY.
REQ-019 In ICW3, wr with a0=1 SHALL be accepted and ignored (cascade unused), then go to READY.
REQ-020 In IDLE, ICW2 and ICW3, writes that do not match REQ-017..019 SHALL be ignored.
REQ-021 In READY, wr with a0=1 (OCW1) SHALL load IMR=din[N_IRQ-1:0].
REQ-022 In READY, wr with a0=0 and din[4:3]=00 (OCW2) SHALL decode din[7:5]. L is din[IDW-1:0].
- 001: non-specific EOI; clears the highest-priority ISR bit.
- 011: specific EOI; clears ISR[L].
- 101: non-specific EOI, then lp=cleared level.
- 111: specific EOI, then lp=L.
- 110: lp=L.
- 100: rotate-in-AEOI=1.
- 000: rotate-in-AEOI=0.
- 010: no operation.
REQ-023 In READY, wr with a0=0 and din[4:3]=01 (OCW3) SHALL latch rdsel=din[0] when din[1]=1 (0=IRR, 1=ISR); reset value of rdsel is 0.
REQ-024 rd SHALL update dout on the next edge: IMR when a0=1, else IRR or ISR per rdsel. Upper bits are zero-filled when N_IRQ<8.
REQ-025 Priority order: level (lp+1) mod N_IRQ is highest, lp is lowest. Wrap-around is modulo N_IRQ.
REQ-026 IRR, edge mode (LTIM=0): set on an irq 0->1 transition; cleared when irq goes low or the bit is acknowledged.
REQ-027 IRR, level mode (LTIM=1): IRR follows irq each cycle.
REQ-028 A request is eligible when its IRR bit is 1, its IMR bit is 0, and its priority is strictly higher than every set ISR bit.
REQ-029 intr SHALL be 1 one cycle after an eligible request exists, when init_done=1 and no acknowledge sequence is open.
REQ-030 First inta: resolve the highest eligible level id, set ISR[id], clear IRR[id] in edge mode, drop intr, and open the sequence.
- If nothing is eligible: id=N_IRQ-1 (spurious) and ISR is unchanged.
REQ-031 Second inta: vec=base|id and vec_valid=1 for exactly one cycle, then close the sequence.
- If AEOI=1: clear ISR[id].
- If AEOI=1 and rotate-in-AEOI=1: also set lp=id.
REQ-032 inta while init_done=0 SHALL be ignored.
REQ-033 wr and inta in the same cycle: the inta action uses pre-write register values, then the write is applied.
- ISR clear and set on the same bit in the same cycle: set wins.
REQ-034 An ICW1 while a sequence is open SHALL abort it; no vec_valid is produced.

Reset
REQ-035 On reset the FSM SHALL enter IDLE.
REQ-036 On reset: intr=0, vec=0, vec_valid=0, dout=0, IMR=0, ISR=0, IRR=0, base=0, lp=N_IRQ-1, LTIM=0, SNGL=0, AEOI=0, rotate-in-AEOI=0, rdsel=0, sequence closed.
REQ-037 Reset asserted mid-sequence or mid-initialisation SHALL take priority over every other input in that cycle.

Verification
REQ-038 Init check.
- Stimulus: ICW1=0x13, ICW2=0x40, irq[3] rises.
- Response: init_done=1 after ICW2; intr=1; inta,inta gives vec=0x43 with vec_valid for one cycle; ISR stays 0 (AEOI).
REQ-039 Priority and nesting.
- Stimulus: ICW1=0x12, ICW2=0x20, irq[5] and irq[2] rise together, then acknowledge.
- Response: vec=0x22, ISR=0x04; intr stays 0 for IR5 until OCW2=0x20, then the next acknowledge gives vec=0x25.
REQ-040 Rotation.
- Stimulus: OCW2=0xC4 (lp=4), irq[3] and irq[6] rise.
- Response: acknowledge gives vec=base|6.
REQ-041 Masking and readback.
- Stimulus: OCW1=0xFF, irq[1] rises.
- Response: intr=0; rd with a0=1 gives dout=0xFF; OCW3=0x0A then rd with a0=0 gives dout=0x02.
REQ-042 Spurious and abort.
- Stimulus: irq[2] drops before the first inta.
- Response: vec=base|7, ISR unchanged.
- Stimulus: ICW1 between the two intas.
- Response: no vec_valid, init_done=0.
REQ-043 Parameter sweep: scenarios REQ-038..041 SHALL pass at N_IRQ=4 with levels mapped modulo 4.
